// File: rtl/psc_frame_arbiter.sv
// rtl/psc_frame_arbiter.sv - frame arbiter: priority trigger plus round-robin requesters 1..3
// Issues one FRAME_LEN-byte frame per grant, then holds off GAP_CYCLES clocks.
module psc_frame_arbiter #(
  parameter int FRAME_LEN  = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig_pulse,
  input  logic [2:0] req,
  input  logic       byte_ready,
  output logic [3:0] grant,
  output logic       frame_start,
  output logic       byte_valid,
  output logic [3:0] byte_addr,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] trig_overrun_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, SEND, GAP} state_t;

  localparam logic [3:0] LAST_ADDR = 4'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_LAST  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t     state_q;
  logic [3:0] grant_q;
  logic       frame_start_q;
  logic       byte_valid_q;
  logic [3:0] addr_q;
  logic [3:0] gap_q;
  logic       trig_pend_q;
  logic [7:0] ovr_q;
  logic [1:0] rr_q;

  logic       trig_eff;
  logic       grant_trig;
  logic       xfer;
  logic       last_xfer;
  logic       rr_hit;
  logic [1:0] rr_idx;

  // A pulse arriving in IDLE is granted immediately, giving one-cycle request-to-grant latency.
  assign trig_eff   = trig_pend_q | trig_pulse;
  assign grant_trig = (state_q == IDLE) && trig_eff;
  assign xfer       = (state_q == SEND) && byte_valid_q && byte_ready;
  assign last_xfer  = xfer && (addr_q == LAST_ADDR);

  always_comb begin
    rr_hit = 1'b0;
    rr_idx = rr_q;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = int'(rr_q) + k;
      if (c >= 3) c = c - 3;
      if (!rr_hit && req[c]) begin
        rr_hit = 1'b1;
        rr_idx = 2'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      frame_start_q <= 1'b0;
      byte_valid_q  <= 1'b0;
      addr_q        <= 4'd0;
      gap_q         <= 4'd0;
      trig_pend_q   <= 1'b0;
      ovr_q         <= 8'd0;
      rr_q          <= 2'd0;
    end else begin
      // A pulse coinciding with the grant of an already-pending trigger re-arms the flag.
      if (grant_trig) begin
        trig_pend_q <= trig_pend_q & trig_pulse;
      end else if (trig_pulse) begin
        trig_pend_q <= 1'b1;
        if (trig_pend_q && (ovr_q != 8'hFF)) ovr_q <= ovr_q + 8'd1;
      end

      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trig_eff) begin
            grant_q       <= 4'b0001;
            frame_start_q <= 1'b1;
            state_q       <= GRANT;
          end else if (rr_hit) begin
            grant_q       <= 4'b0010 << rr_idx;
            rr_q          <= (rr_idx == 2'd2) ? 2'd0 : rr_idx + 2'd1;
            frame_start_q <= 1'b1;
            state_q       <= GRANT;
          end
        end
        GRANT: begin
          addr_q       <= 4'd0;
          byte_valid_q <= 1'b1;
          state_q      <= SEND;
        end
        SEND: begin
          if (last_xfer) begin
            byte_valid_q <= 1'b0;
            grant_q      <= 4'b0000;
            addr_q       <= 4'd0;
            gap_q        <= 4'd0;
            state_q      <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (xfer) begin
            addr_q <= addr_q + 4'd1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= 4'd0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant            = grant_q;
  assign frame_start      = frame_start_q;
  assign byte_valid       = byte_valid_q;
  assign byte_addr        = addr_q;
  assign frame_done       = last_xfer;
  assign busy             = (state_q != IDLE);
  assign trig_overrun_cnt = ovr_q;

endmodule
